// File: rtl/fifo_ring_pkg.sv
// Shared types and constants for the fifo_ring_flex ring FIFO family.
package fifo_ring_pkg;

    typedef enum logic {
        RD_STD,
        RD_FWFT
    } rd_mode_t;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/fifo_ring_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
module fifo_ring_ram
    import fifo_ring_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register takes a sync reset so the FIFO output reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_ring_flex.sv
// Single-clock ring FIFO with standard or first-word-fall-through read,
// threshold flags, sticky error flags and a saturating dropped-write count.
module fifo_ring_flex
    import fifo_ring_pkg::*;
#(
    parameter int       RAM_WIDTH     = 32,
    parameter int       RAM_DEPTH     = 256,
    parameter rd_mode_t RD_MODE       = RD_STD,
    parameter int       AFULL_THRESH  = RAM_DEPTH - 4,
    parameter int       AEMPTY_THRESH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_wr_valid,
    input  logic [RAM_WIDTH-1:0]        i_wr_data,
    input  logic                        i_rd_en,
    output logic                        o_rd_valid,
    output logic [RAM_WIDTH-1:0]        o_rd_data,
    output logic                        o_ready,
    output logic                        o_empty,
    output logic                        o_full,
    output logic                        o_almost_full,
    output logic                        o_almost_empty,
    output logic                        o_overflow,
    output logic                        o_underflow,
    input  logic                        i_clr_flags,
    output logic [DROP_CNT_W-1:0]       o_drop_count,
    output logic [$clog2(RAM_DEPTH):0]  o_fill_count
);

    localparam int AW = $clog2(RAM_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(RAM_DEPTH);
    localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_THRESH);
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;
    localparam bit FWFT = (RD_MODE == RD_FWFT);

    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         fill_q;     // words held, including the FWFT output word
    logic [CW-1:0]         ram_cnt;    // words still in RAM, not yet read out
    logic                  rd_valid_q;
    logic                  overflow_q, underflow_q;
    logic [DROP_CNT_W-1:0] drop_q;
    logic                  wr_acc, wr_rej, pop, rd_bad, ram_re;
    logic [RAM_WIDTH-1:0]  ram_rdata;

    // Handshake: a write transfers when i_wr_valid && o_ready at the rising edge.
    // STD: i_rd_en && !o_empty requests a word, delivered with o_rd_valid one cycle later.
    // FWFT: o_rd_valid/o_rd_data present the head word; i_rd_en && o_rd_valid pops it.
    always_comb begin
        wr_acc = i_wr_valid && !o_full;
        wr_rej = i_wr_valid && o_full;
        if (FWFT) begin
            pop    = i_rd_en && rd_valid_q;
            rd_bad = i_rd_en && !rd_valid_q;
            ram_re = (ram_cnt != '0) && (!rd_valid_q || pop);
        end else begin
            pop    = i_rd_en && !o_empty;
            rd_bad = i_rd_en && o_empty;
            ram_re = pop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_q     <= '0;
            ram_cnt    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_acc && !pop) begin
                fill_q <= fill_q + CW'(1);
            end else if (!wr_acc && pop) begin
                fill_q <= fill_q - CW'(1);
            end
            if (wr_acc && !ram_re) begin
                ram_cnt <= ram_cnt + CW'(1);
            end else if (!wr_acc && ram_re) begin
                ram_cnt <= ram_cnt - CW'(1);
            end
            // STD valid is a one-cycle pulse; FWFT valid holds until popped.
            if (ram_re) begin
                rd_valid_q <= 1'b1;
            end else if (pop || !FWFT) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    // A new error event in the same cycle as a clear takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            if (wr_rej) begin
                overflow_q <= 1'b1;
                if (i_clr_flags) begin
                    drop_q <= DROP_CNT_W'(1);
                end else if (drop_q != DROP_MAX) begin
                    drop_q <= drop_q + DROP_CNT_W'(1);
                end
            end else if (i_clr_flags) begin
                overflow_q <= 1'b0;
                drop_q     <= '0;
            end
            if (rd_bad) begin
                underflow_q <= 1'b1;
            end else if (i_clr_flags) begin
                underflow_q <= 1'b0;
            end
        end
    end

    fifo_ring_ram #(
        .WIDTH (RAM_WIDTH),
        .DEPTH (RAM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (i_wr_data),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    assign o_rd_valid     = rd_valid_q;
    assign o_rd_data      = ram_rdata;
    assign o_fill_count   = fill_q;
    assign o_empty        = (fill_q == '0);
    assign o_full         = (fill_q == FULL_CNT);
    assign o_ready        = !o_full;
    assign o_almost_full  = (fill_q >= AFULL_CNT);
    assign o_almost_empty = (fill_q <= AEMPTY_CNT);
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;
    assign o_drop_count   = drop_q;

endmodule

// File: tb/tb_fifo_ring_flex.sv
// Directed scoreboard bench for fifo_ring_flex: one STD and one FWFT instance.
`timescale 1ns/1ps
module tb_fifo_ring_flex;
    import fifo_ring_pkg::*;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AF = 12;
    localparam int AE = 3;
    localparam int CW = $clog2(D) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- STD instance ----------------
    logic                  s_wr_valid, s_rd_en, s_clr;
    logic [W-1:0]          s_wr_data;
    logic                  s_o_rd_valid, s_o_ready, s_o_empty, s_o_full;
    logic                  s_o_afull, s_o_aempty, s_o_ovf, s_o_udf;
    logic [W-1:0]          s_o_rd_data;
    logic [DROP_CNT_W-1:0] s_o_drop;
    logic [CW-1:0]         s_o_fill;

    fifo_ring_flex #(
        .RAM_WIDTH(W), .RAM_DEPTH(D), .RD_MODE(RD_STD),
        .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
    ) u_std (
        .clk(clk), .rst(rst),
        .i_wr_valid(s_wr_valid), .i_wr_data(s_wr_data), .i_rd_en(s_rd_en),
        .o_rd_valid(s_o_rd_valid), .o_rd_data(s_o_rd_data), .o_ready(s_o_ready),
        .o_empty(s_o_empty), .o_full(s_o_full), .o_almost_full(s_o_afull),
        .o_almost_empty(s_o_aempty), .o_overflow(s_o_ovf), .o_underflow(s_o_udf),
        .i_clr_flags(s_clr), .o_drop_count(s_o_drop), .o_fill_count(s_o_fill)
    );

    // ---------------- FWFT instance ----------------
    logic                  f_wr_valid, f_rd_en, f_clr;
    logic [W-1:0]          f_wr_data;
    logic                  f_o_rd_valid, f_o_ready, f_o_empty, f_o_full;
    logic                  f_o_afull, f_o_aempty, f_o_ovf, f_o_udf;
    logic [W-1:0]          f_o_rd_data;
    logic [DROP_CNT_W-1:0] f_o_drop;
    logic [CW-1:0]         f_o_fill;

    fifo_ring_flex #(
        .RAM_WIDTH(W), .RAM_DEPTH(D), .RD_MODE(RD_FWFT),
        .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
    ) u_fwft (
        .clk(clk), .rst(rst),
        .i_wr_valid(f_wr_valid), .i_wr_data(f_wr_data), .i_rd_en(f_rd_en),
        .o_rd_valid(f_o_rd_valid), .o_rd_data(f_o_rd_data), .o_ready(f_o_ready),
        .o_empty(f_o_empty), .o_full(f_o_full), .o_almost_full(f_o_afull),
        .o_almost_empty(f_o_aempty), .o_overflow(f_o_ovf), .o_underflow(f_o_udf),
        .i_clr_flags(f_clr), .o_drop_count(f_o_drop), .o_fill_count(f_o_fill)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] s_model_q[$];
    logic [W-1:0] s_exp_q[$];
    logic [W-1:0] f_model_q[$];
    logic [W-1:0] f_exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_std_reset(input string tag);
        check({tag, "_empty"},  32'(s_o_empty),    32'd1);
        check({tag, "_ready"},  32'(s_o_ready),    32'd1);
        check({tag, "_aempty"}, 32'(s_o_aempty),   32'd1);
        check({tag, "_full"},   32'(s_o_full),     32'd0);
        check({tag, "_afull"},  32'(s_o_afull),    32'd0);
        check({tag, "_valid"},  32'(s_o_rd_valid), 32'd0);
        check({tag, "_data"},   s_o_rd_data,       32'd0);
        check({tag, "_fill"},   32'(s_o_fill),     32'd0);
        check({tag, "_ovf"},    32'(s_o_ovf),      32'd0);
        check({tag, "_udf"},    32'(s_o_udf),      32'd0);
        check({tag, "_drop"},   32'(s_o_drop),     32'd0);
        check({tag, "_fvalid"}, 32'(f_o_rd_valid), 32'd0);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && s_o_rd_valid) begin
            if (s_exp_q.size() == 0) begin
                check("std_unexpected_valid", 32'(s_exp_q.size()), 32'd1);
            end else begin
                check("std_rd_data", s_o_rd_data, s_exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && f_o_rd_valid && f_rd_en) begin
            if (f_exp_q.size() == 0) begin
                check("fwft_unexpected_pop", 32'(f_exp_q.size()), 32'd1);
            end else begin
                check("fwft_rd_data", f_o_rd_data, f_exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        s_wr_valid = 0; s_rd_en = 0; s_clr = 0; s_wr_data = '0;
        f_wr_valid = 0; f_rd_en = 0; f_clr = 0; f_wr_data = '0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        check_std_reset("rst");

        // fill 1..16 with threshold crossings
        for (int i = 1; i <= D; i++) begin
            s_wr_valid = 1;
            s_wr_data  = W'(i);
            s_model_q.push_back(W'(i));
            tick();
            if (i == 3)  check("aempty_w3",  32'(s_o_aempty), 32'd1);
            if (i == 4)  check("aempty_w4",  32'(s_o_aempty), 32'd0);
            if (i == 11) check("afull_w11",  32'(s_o_afull),  32'd0);
            if (i == 12) check("afull_w12",  32'(s_o_afull),  32'd1);
        end
        s_wr_valid = 0;
        check("full_after16",  32'(s_o_full),  32'd1);
        check("ready_after16", 32'(s_o_ready), 32'd0);
        check("fill_after16",  32'(s_o_fill),  32'd16);

        // overflow while full, then clear colliding with a new drop
        for (int i = 0; i < 3; i++) begin
            s_wr_valid = 1;
            s_wr_data  = W'(32'hBAD0 + i);
            tick();
        end
        s_wr_valid = 0;
        check("ovf_set",    32'(s_o_ovf),  32'd1);
        check("drop_3",     32'(s_o_drop), 32'd3);
        check("fill_ovf",   32'(s_o_fill), 32'd16);
        s_wr_valid = 1;
        s_wr_data  = 32'hBAD9;
        s_clr      = 1;
        tick();
        s_wr_valid = 0;
        s_clr      = 0;
        check("ovf_clr_collide",  32'(s_o_ovf),  32'd1);
        check("drop_clr_collide", 32'(s_o_drop), 32'd1);
        s_clr = 1;
        tick();
        s_clr = 0;
        check("ovf_cleared",  32'(s_o_ovf),  32'd0);
        check("drop_cleared", 32'(s_o_drop), 32'd0);

        // drain 16; contents must be 1..16
        for (int i = 1; i <= D; i++) begin
            s_rd_en = 1;
            s_exp_q.push_back(s_model_q.pop_front());
            tick();
            if (i == 1) check("std_latency", 32'(s_o_rd_valid), 32'd1);
            if (i == 4) check("afull_r4",    32'(s_o_afull),    32'd1);
            if (i == 5) check("afull_r5",    32'(s_o_afull),    32'd0);
        end
        s_rd_en = 0;
        tick();
        check("empty_drained",  32'(s_o_empty),    32'd1);
        check("aempty_drained", 32'(s_o_aempty),   32'd1);
        check("udf_none",       32'(s_o_udf),      32'd0);
        check("valid_drained",  32'(s_o_rd_valid), 32'd0);

        // underflow on empty with a simultaneous write
        s_rd_en    = 1;
        s_wr_valid = 1;
        s_wr_data  = 32'h55;
        s_model_q.push_back(32'h55);
        tick();
        s_rd_en    = 0;
        s_wr_valid = 0;
        check("udf_set",   32'(s_o_udf),      32'd1);
        check("udf_fill",  32'(s_o_fill),     32'd1);
        check("udf_valid", 32'(s_o_rd_valid), 32'd0);

        for (int k = 1; k <= 7; k++) begin
            s_wr_valid = 1;
            s_wr_data  = W'(32'h200 + k);
            s_model_q.push_back(W'(32'h200 + k));
            tick();
        end
        s_wr_valid = 0;
        check("fill_8", 32'(s_o_fill), 32'd8);

        // simultaneous write+read at fill 8, wrapping the pointers
        for (int k = 0; k < 40; k++) begin
            s_wr_valid = 1;
            s_wr_data  = W'(32'h300 + k);
            s_rd_en    = 1;
            s_exp_q.push_back(s_model_q.pop_front());
            s_model_q.push_back(W'(32'h300 + k));
            tick();
            check("simul_fill", 32'(s_o_fill), 32'd8);
        end
        s_wr_valid = 0;
        for (int k = 0; k < 8; k++) begin
            s_rd_en = 1;
            s_exp_q.push_back(s_model_q.pop_front());
            tick();
        end
        s_rd_en = 0;
        tick();
        check("empty_after_simul", 32'(s_o_empty), 32'd1);

        // reset mid-operation at fill 10
        for (int k = 0; k < 10; k++) begin
            s_wr_valid = 1;
            s_wr_data  = W'(32'h400 + k);
            tick();
        end
        s_wr_valid = 0;
        check("fill_10", 32'(s_o_fill), 32'd10);
        rst = 1;
        tick();
        rst = 0;
        check_std_reset("midrst");
        s_wr_valid = 1;
        s_wr_data  = 32'h77;
        s_model_q.push_back(32'h77);
        tick();
        s_wr_valid = 0;
        s_rd_en    = 1;
        s_exp_q.push_back(s_model_q.pop_front());
        tick();
        s_rd_en = 0;
        check("first_after_rst", s_o_rd_data, 32'h77);
        tick();

        // FWFT single word latency
        f_wr_valid = 1;
        f_wr_data  = 32'hA5;
        f_model_q.push_back(32'hA5);
        tick();
        f_wr_valid = 0;
        check("fwft_lat_edge1", 32'(f_o_rd_valid), 32'd0);
        check("fwft_fill1",     32'(f_o_fill),     32'd1);
        tick();
        check("fwft_lat_edge2", 32'(f_o_rd_valid), 32'd1);
        check("fwft_head_a5",   f_o_rd_data,       32'hA5);
        f_rd_en = 1;
        f_exp_q.push_back(f_model_q.pop_front());
        tick();
        f_rd_en = 0;
        check("fwft_valid_drop", 32'(f_o_rd_valid), 32'd0);
        check("fwft_empty",      32'(f_o_empty),    32'd1);

        // FWFT streaming: writes 0..29, pops every cycle from cycle 2
        for (int k = 0; k < 32; k++) begin
            f_wr_valid = (k < 30);
            f_wr_data  = W'(32'h1000 + k);
            if (k < 30) f_model_q.push_back(W'(32'h1000 + k));
            f_rd_en = (k >= 2);
            if (k >= 2) begin
                check("fwft_no_gap", 32'(f_o_rd_valid), 32'd1);
                f_exp_q.push_back(f_model_q.pop_front());
            end
            tick();
            if (k >= 2 && k < 30) check("fwft_stream_fill", 32'(f_o_fill), 32'd2);
        end
        f_wr_valid = 0;
        f_rd_en    = 0;
        check("fwft_end_valid", 32'(f_o_rd_valid), 32'd0);
        check("fwft_end_empty", 32'(f_o_empty),    32'd1);
        check("fwft_end_udf",   32'(f_o_udf),      32'd0);
        tick();

        // ---------------- report ----------------
        check("std_exp_left",  32'(s_exp_q.size()), 32'd0);
        check("fwft_exp_left", 32'(f_exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_ring_flex.md
# fifo_ring_flex

Parametrised single-clock ring FIFO for the sample/event datapaths. It adds a selectable read mode: standard (registered read) or first-word-fall-through (FWFT). It also provides threshold-based almost-full/almost-empty flags, sticky overflow/underflow error flags and a saturating count of dropped writes. It sits between producers and consumers that need backpressure headroom or zero-latency head-of-queue visibility.

## Interface
Parameters:
- RAM_WIDTH, 32, data word width in bits.
- RAM_DEPTH, 256, capacity in words. Power of two, at least 4.
- RD_MODE, RD_STD, read mode from the package enum: RD_STD or RD_FWFT.
- AFULL_THRESH, RAM_DEPTH-4, o_almost_full asserts when fill count is at least this value. Range 1..RAM_DEPTH.
- AEMPTY_THRESH, 4, o_almost_empty asserts when fill count is at most this value. Range 0..RAM_DEPTH-1.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_wr_valid  in  1  write request.
- i_wr_data  in  RAM_WIDTH  write data.
- i_rd_en  in  1  RD_STD: read request. RD_FWFT: pop/acknowledge of the presented word.
- o_rd_valid  out  1  o_rd_data holds a valid word.
- o_rd_data  out  RAM_WIDTH  read data.
- o_ready  out  1  equals !o_full.
- o_empty  out  1  fill count is 0.
- o_full  out  1  fill count equals RAM_DEPTH.
- o_almost_full  out  1  fill count is at least AFULL_THRESH.
- o_almost_empty  out  1  fill count is at most AEMPTY_THRESH.
- o_overflow  out  1  sticky: a write was attempted while full.
- o_underflow  out  1  sticky: a read was attempted with no data.
- i_clr_flags  in  1  clears o_overflow, o_underflow and o_drop_count.
- o_drop_count  out  16  saturating count of rejected writes.
- o_fill_count  out  $clog2(RAM_DEPTH)+1  words held, including any FWFT output-stage word.

## Operation
- Accepted write: i_wr_valid && !o_full. The word is stored at wr_ptr and wr_ptr advances.
- Rejected write: i_wr_valid && o_full. Data is discarded, o_overflow is set, and o_drop_count increments, saturating at 0xFFFF.
- A write is rejected when full even if a read occurs in the same cycle. No pass-through.
- RD_STD:
  - Accepted read: i_rd_en && !o_empty.
  - i_rd_en && o_empty sets o_underflow and has no other effect, even if a write occurs in the same cycle.
- RD_FWFT:
  - A one-word output register is prefetched from RAM whenever it is empty or being popped and RAM holds data.
  - Accepted pop: i_rd_en && o_rd_valid.
  - i_rd_en && !o_rd_valid sets o_underflow.
- Fill count: +1 on an accepted write, -1 on an accepted read/pop, unchanged when both occur. All flags decode from the registered fill count.
- Pointers are $clog2(RAM_DEPTH) bits and wrap naturally from RAM_DEPTH-1 to 0. Data order is strictly preserved across wrap.
- i_clr_flags: the clear applies at the next edge. A new overflow, underflow or drop in the same cycle wins: the flag stays set and the count becomes 1.
- Reset, including mid-operation: content is discarded and the pointers are zeroed.
- Reset values:
  - o_empty=1, o_ready=1, o_almost_empty=1.
  - o_full=0, o_almost_full=0, o_rd_valid=0.
  - o_rd_data=0, o_fill_count=0.
  - o_overflow=0, o_underflow=0, o_drop_count=0.

## Timing
- All outputs are registered or decoded from registers. No combinational path from any input to any output.
- RD_STD read latency is 1. An accepted read at edge N gives o_rd_valid=1 with the data after N, for exactly one cycle per accepted read. Back-to-back reads give continuous valid.
- RD_FWFT write-to-visible latency is 2. A write at edge N gives o_rd_valid=1 after edge N+1. Pop at edge N shows the next word after N if RAM holds it, otherwise o_rd_valid drops.
- RD_FWFT sustains one pop per cycle at steady state.
- Flag latency is 1. Flags reflect the fill count after the edge that changed it.
- o_ready deasserts in the cycle after the RAM_DEPTH-th accepted write.

## Structure
- Package fifo_ring_pkg holds:
  - typedef enum rd_mode_t {RD_STD, RD_FWFT}.
  - localparam DROP_CNT_W = 16.
- Sub-module fifo_ring_ram: simple dual-port RAM with one write port, one read port and a registered read, inferring block RAM.
- The top-level holds the pointers, fill counter, FWFT output stage and flag/error logic.

## Test plan
Bench parameters: RAM_WIDTH=32, RAM_DEPTH=16, AFULL_THRESH=12, AEMPTY_THRESH=3.
- Fill and drain, RD_STD: write 1..16 back-to-back, then read 16.
  - After the 16th write: o_full=1, o_ready=0, o_fill_count=16.
  - Reads return 1..16 in order, each one cycle after its i_rd_en.
  - Then o_empty=1 and o_almost_empty=1.
- Thresholds: o_almost_full rises after the 12th write and falls after the pop that takes the count to 11. o_almost_empty falls after the 4th write.
- Overflow when full: 3 extra writes give o_overflow=1 and o_drop_count=3, with content unchanged. Then i_clr_flags pulsed alongside one more rejected write gives o_overflow=1 and o_drop_count=1.
- Underflow and simultaneity: i_rd_en on empty gives o_underflow=1. Simultaneous write and read at fill 8 for 40 cycles gives o_fill_count constant at 8, pointers wrapping, and values in order.
- RD_FWFT: a single write of 0xA5 shows o_rd_valid=1 with 0xA5 two edges later. A continuous pop stream against a continuous write stream gives one word per cycle with no gaps or duplicates.
- Reset mid-operation: rst pulsed at fill 10 gives all outputs at reset values on the next cycle. The next write of 0x77 is the first word read.
